// File: rtl/one_func4.sv
// one_func4: clocked 4-input Boolean function unit driven by a rewritable
// 16-entry truth table. Minterm index is {A,B,C,D} with A as the MSB.
// Optional minterm coverage tracking is built when ONE_COVERAGE_EN is defined.
module one_func4 #(
    parameter logic [15:0] TRUTH_TABLE = 16'h0727
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        A,
    input  logic        B,
    input  logic        C,
    input  logic        D,
    input  logic        tt_we,
    input  logic [15:0] tt_wdata,
`ifdef ONE_COVERAGE_EN
    output logic [15:0] cov,
    output logic        cov_full,
`endif
    output logic        f_comb,
    output logic        f
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned TT_W  = 16;

    logic [TT_W-1:0]  tt_q;
    logic [IDX_W-1:0] idx;

    assign idx = {A, B, C, D};

    // Combinational lookup against the live table register
    assign f_comb = tt_q[idx];

    // Table storage and registered evaluation; f always sees the pre-edge table
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_q <= TRUTH_TABLE;
            f    <= 1'b0;
        end else begin
            f <= tt_q[idx];
            if (tt_we) begin
                tt_q <= tt_wdata;
            end
        end
    end

`ifdef ONE_COVERAGE_EN
    // Sticky minterm coverage; a table write restarts it and skips that edge's minterm
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cov <= '0;
        end else if (tt_we) begin
            cov <= '0;
        end else begin
            cov[idx] <= 1'b1;
        end
    end

    // All minterms seen
    assign cov_full = &cov;
`endif

endmodule

// File: tb/tb_one_func4.sv
// tb_one_func4: directed bench for one_func4 with a behavioural model checked
// on every falling edge, plus literal expectations from hand-worked vectors.
// Coverage checks are compiled in when ONE_COVERAGE_EN is defined.
module tb_one_func4;

    localparam logic [15:0] RESET_TT = 16'h0727;

    logic        clk;
    logic        rst;
    logic        A, B, C, D;
    logic        tt_we;
    logic [15:0] tt_wdata;
    logic        f_comb;
    logic        f;
`ifdef ONE_COVERAGE_EN
    logic [15:0] cov;
    logic        cov_full;
`endif

    int total = 0;
    int bad   = 0;

    // hand-derived f sequence for the reset table, minterms 0..15
    int exp_seq [16] = '{1,1,1,0,0,1,0,0,1,1,1,0,0,0,0,0};

    one_func4 #(.TRUTH_TABLE(RESET_TT)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .tt_we    (tt_we),
        .tt_wdata (tt_wdata),
`ifdef ONE_COVERAGE_EN
        .cov      (cov),
        .cov_full (cov_full),
`endif
        .f_comb   (f_comb),
        .f        (f)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_tt;
    logic        m_f;
    logic [15:0] m_cov;

    function automatic int cur_idx();
        return 8 * int'(A) + 4 * int'(B) + 2 * int'(C) + int'(D);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tt  <= RESET_TT;
            m_f   <= 1'b0;
            m_cov <= 16'h0000;
        end else begin
            m_f <= m_tt[cur_idx()];
            if (tt_we) begin
                m_tt  <= tt_wdata;
                m_cov <= 16'h0000;
            end else begin
                m_cov <= m_cov | (16'h0001 << cur_idx());
            end
        end
    end

    // Compare DUT against model every cycle, away from the active edge
    always @(negedge clk) begin
        chk("model_f_comb", 16'(f_comb), 16'(m_tt[cur_idx()]));
        chk("model_f", 16'(f), 16'(m_f));
`ifdef ONE_COVERAGE_EN
        chk("model_cov", cov, m_cov);
        chk("model_cov_full", 16'(cov_full), 16'(m_cov == 16'hFFFF));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic apply(input int i, input logic we, input logic [15:0] wd);
        @(negedge clk);
        #2;
        {A, B, C, D} = 4'(i);
        tt_we    = we;
        tt_wdata = wd;
    endtask

    task automatic sweep_default(input string tag);
        for (int i = 0; i < 16; i++) begin
            apply(i, 1'b0, 16'h0000);
            #5;
            chk({tag, "_f_comb"}, 16'(f_comb), 16'(exp_seq[i]));
            @(posedge clk);
            #1;
            chk({tag, "_f"}, 16'(f), 16'(exp_seq[i]));
        end
    endtask

    task automatic sweep_plain();
        for (int i = 0; i < 16; i++) begin
            apply(i, 1'b0, 16'h0000);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        {A, B, C, D} = 4'b0000;
        tt_we = 1'b0;
        tt_wdata = 16'h0000;
        #3 rst = 1'b1;
        #5;
        chk("rst_f", 16'(f), 16'h0000);
        chk("rst_f_comb_0000", 16'(f_comb), 16'h0001);
`ifdef ONE_COVERAGE_EN
        chk("rst_cov", cov, 16'h0000);
`endif
        @(negedge clk);
        #4 rst = 1'b0;

        // default table sweep
        sweep_default("sweep");
`ifdef ONE_COVERAGE_EN
        chk("sweep_cov", cov, 16'hFFFF);
        chk("sweep_cov_full", 16'(cov_full), 16'h0001);
`endif

        // table write at minterm 1: f uses old table, f_comb the new one
        apply(1, 1'b1, 16'h6996);
        @(posedge clk);
        #1;
        chk("wr_f_old_table", 16'(f), 16'h0001);
        chk("wr_f_comb_new", 16'(f_comb), 16'h0001);
`ifdef ONE_COVERAGE_EN
        chk("wr_cov_cleared", cov, 16'h0000);
        chk("wr_cov_full_low", 16'(cov_full), 16'h0000);
`endif
        apply(3, 1'b0, 16'h0000);
        #5;
        chk("par_f_comb_0011", 16'(f_comb), 16'h0000);
        @(posedge clk);
        #1;
        chk("par_f_0011", 16'(f), 16'h0000);
        apply(7, 1'b0, 16'h0000);
        #5;
        chk("par_f_comb_0111", 16'(f_comb), 16'h0001);

`ifdef ONE_COVERAGE_EN
        // full sweep, write clears, re-sweep refills
        sweep_plain();
        chk("cov2_full", cov, 16'hFFFF);
        apply(4, 1'b1, 16'h6996);
        @(posedge clk);
        #1;
        chk("cov2_clear", cov, 16'h0000);
        chk("cov2_full_low", 16'(cov_full), 16'h0000);
        sweep_plain();
        chk("cov3_full", 16'(cov_full), 16'h0001);

        // partial coverage after a clearing write
        apply(9, 1'b1, 16'h6996);
        apply(0, 1'b0, 16'h0000);
        apply(5, 1'b0, 16'h0000);
        apply(5, 1'b0, 16'h0000);
        apply(15, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        chk("partial_cov", cov, 16'h8021);
        chk("partial_cov_full", 16'(cov_full), 16'h0000);
`endif

        // reset during activity with a written table
        apply(2, 1'b1, 16'h1234);
        apply(5, 1'b0, 16'h0000);
        apply(6, 1'b0, 16'h0000);
        #5;
        chk("pre_rst_f_comb", 16'(f_comb), 16'h0000);
        @(posedge clk);
        #5 rst = 1'b1;
        #1;
        chk("mid_rst_f", 16'(f), 16'h0000);
        chk("mid_rst_f_comb", 16'(f_comb), 16'h0000);
`ifdef ONE_COVERAGE_EN
        chk("mid_rst_cov", cov, 16'h0000);
`endif
        {A, B, C, D} = 4'b0101;
        #1;
        chk("mid_rst_f_comb_0101", 16'(f_comb), 16'h0001);
        @(posedge clk);
        #1;
        chk("rst_hold_f", 16'(f), 16'h0000);
        @(negedge clk);
        #4 rst = 1'b0;

        sweep_default("resume");
`ifdef ONE_COVERAGE_EN
        chk("resume_cov_full", 16'(cov_full), 16'h0001);
`endif

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/one_func4.md
Name: one_func4

Overview:
- Clocked 4-input Boolean function unit. Evaluates a single-bit function f(A,B,C,D) from a 16-entry truth table.
- The truth table is fixed at reset by a parameter and can be rewritten at run time.
- Used as a small programmable-logic leaf: combinational and registered results, plus optional input-minterm coverage tracking for self-check sweeps.

Parameters:
- TRUTH_TABLE, 16'h0727, reset contents of the table. Bit i is f for minterm i = {A,B,C,D} with A as MSB. The default is f = 1 for minterms 0,1,2,5,8,9,10.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- A  input  1  function input, minterm index bit 3 (MSB)
- B  input  1  function input, index bit 2
- C  input  1  function input, index bit 1
- D  input  1  function input, index bit 0 (LSB)
- tt_we  input  1  truth-table write enable
- tt_wdata  input  16  new truth-table contents
- f_comb  output  1  combinational result: table[{A,B,C,D}]
- f  output  1  registered result
- cov  output  16  minterm coverage bitmap (present only with ONE_COVERAGE_EN)
- cov_full  output  1  all 16 minterms seen (present only with ONE_COVERAGE_EN)

Behaviour:
- Reset:
  - Asynchronous on rst high, held while rst = 1.
  - table = TRUTH_TABLE, f = 0, cov = 16'h0000, cov_full = 0.
- idx = {A,B,C,D}, an unsigned value 0..15.
- f_comb:
  - Pure combinational: table[idx], using the current table register. No clock latency.
  - During reset it reflects the TRUTH_TABLE contents.
- f:
  - Each rising edge with rst low: f <= table[idx], one-cycle latency.
  - Evaluation uses the table value held before the edge.
- Table write:
  - On a rising edge with tt_we = 1: table <= tt_wdata.
  - The new table affects f_comb immediately after the edge and f from the next edge onward.
  - On a simultaneous write and evaluation, f uses the old table.
- The table register holds its value when tt_we = 0.
- X/Z on A..D is not guarded; callers drive known values.
- No handshake. Inputs are sampled every cycle.

Optional Feature:
- Macro ONE_COVERAGE_EN.
- Defined:
  - Each rising edge with rst low and tt_we low: cov[idx] <= 1 (sticky).
  - On a rising edge with tt_we = 1: cov <= 0, and the minterm on that edge is not recorded. A table change restarts coverage.
  - cov_full = &cov, combinational from the cov register. It rises the cycle after the last missing minterm is recorded.
  - Repeated minterms have no effect beyond their first recording.
- Not defined:
  - cov and cov_full ports are omitted and no coverage logic is built.
  - All other behaviour is unchanged.

Test Plan:
- Reset: assert rst mid-cycle -> f = 0 immediately, f_comb = TRUTH_TABLE bit of current idx, cov = 0. With ABCD = 0000 -> f_comb = 1.
- Default sweep: ABCD from 0000 to 1111, 20 ns per vector, idx ascending.
  - f_comb sequence is 1,1,1,0,0,1,0,0,1,1,1,0,0,0,0,0.
  - f matches the same sequence one clock later.
  - With ONE_COVERAGE_EN: cov = 16'hFFFF and cov_full = 1 after the last vector.
- Table write: tt_we = 1, tt_wdata = 16'h6996 (odd parity) while ABCD = 0001.
  - f at that edge = 1 (old table, minterm 1).
  - f_comb after the edge = 1.
  - ABCD = 0011 -> f_comb = 0; f = 0 next edge.
- Write clears coverage (ONE_COVERAGE_EN): after a full sweep, pulse tt_we -> cov = 0 and cov_full = 0. Re-sweep -> cov_full = 1 again.
- Partial coverage: apply minterms 0, 5, 5, 15 only -> cov = 16'h8021, cov_full = 0.
- Reset during activity: rst high while the sweep is mid-way with a written table -> table returns to 16'h0727, f = 0, cov = 0. Operation resumes correctly after rst is released.
